// File: rtl/playback_pkg.sv
// Shared encodings for the playback controller: FSM states, repeat-mode codes, tempo codes.
package playback_pkg;

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'd0,
    ST_PLAYING = 2'd1,
    ST_LOAD    = 2'd2
  } state_e;

  // Code 2'b11 is reserved; on both inputs it behaves like the 2'b00 code.
  localparam logic [1:0] RPT_OFF = 2'b00;
  localparam logic [1:0] RPT_ONE = 2'b01;
  localparam logic [1:0] RPT_ALL = 2'b10;

  localparam logic [1:0] TEMPO_NORMAL = 2'b00;
  localparam logic [1:0] TEMPO_DOUBLE = 2'b01;
  localparam logic [1:0] TEMPO_HALF   = 2'b10;

endpackage

// File: rtl/playback_if.sv
// Control/status bundle between the player front panel, codec, song reader and the controller.
// Buttons and song_done are single-cycle pulses, not a valid/ready handshake: each pulse is one event.
interface playback_if #(parameter int SONG_W = 2);
  import playback_pkg::*;

  logic              play_button;
  logic              next_button;
  logic              prev_button;
  logic [1:0]        repeat_mode;
  logic [1:0]        tempo;
  logic              new_frame;
  logic              song_done;
  logic              play;
  logic              reset_player;
  logic [SONG_W-1:0] song;
  logic              generate_next_sample;
  logic              beat;
  state_e            state;

  modport master (
    output play_button, next_button, prev_button, repeat_mode, tempo, new_frame, song_done,
    input  play, reset_player, song, generate_next_sample, beat, state
  );

  modport slave (
    input  play_button, next_button, prev_button, repeat_mode, tempo, new_frame, song_done,
    output play, reset_player, song, generate_next_sample, beat, state
  );

endinterface

// File: rtl/tempo_beat_counter.sv
// Counts sample pulses and emits a one-cycle beat every L pulses, L chosen live from tempo.
module tempo_beat_counter
  import playback_pkg::*;
#(
  parameter int BEAT_COUNT = 1000,
  parameter int CNT_W      = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic [1:0] tempo,
  output logic       beat
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             beat_q, beat_d;
  logic [CNT_W-1:0] limit_m1;

  always_comb begin
    case (tempo)
      TEMPO_DOUBLE: limit_m1 = CNT_W'(BEAT_COUNT / 2 - 1);
      TEMPO_HALF:   limit_m1 = CNT_W'(2 * BEAT_COUNT - 1);
      default:      limit_m1 = CNT_W'(BEAT_COUNT - 1);
    endcase

    cnt_d  = cnt_q;
    beat_d = 1'b0;
    // Compare with >= so a tempo speed-up past the current count fires on the next pulse.
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q >= limit_m1) begin
        cnt_d  = '0;
        beat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      beat_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      beat_q <= beat_d;
    end
  end

  assign beat = beat_q;

endmodule

// File: rtl/playback_controller.sv
// Play/pause/skip FSM with a one-cycle LOAD state, frame-strobe edge detector and tempo beat counter.
module playback_controller
  import playback_pkg::*;
#(
  parameter int NUM_SONGS  = 4,
  parameter int SONG_W     = 2,
  parameter int BEAT_COUNT = 1000,
  parameter int CNT_W      = 11
) (
  input logic      clk,
  input logic      reset,
  playback_if.slave pb
);

  state_e            state_q, state_d;
  state_e            ret_q, ret_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic              play_q, play_d;
  logic              reset_player_q, reset_player_d;
  logic              new_frame_q, new_frame_d;
  logic              gen_q, gen_d;

  function automatic logic [SONG_W-1:0] song_inc(input logic [SONG_W-1:0] s);
    return (s == SONG_W'(NUM_SONGS - 1)) ? '0 : s + SONG_W'(1);
  endfunction

  function automatic logic [SONG_W-1:0] song_dec(input logic [SONG_W-1:0] s);
    return (s == '0) ? SONG_W'(NUM_SONGS - 1) : s - SONG_W'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    song_d  = song_q;
    // The if/else chain encodes event priority: play > next > prev > song_done.
    case (state_q)
      ST_PAUSED: begin
        if (pb.play_button) begin
          state_d = ST_PLAYING;
        end else if (pb.next_button) begin
          state_d = ST_LOAD; ret_d = ST_PAUSED; song_d = song_inc(song_q);
        end else if (pb.prev_button) begin
          state_d = ST_LOAD; ret_d = ST_PAUSED; song_d = song_dec(song_q);
        end
      end
      ST_PLAYING: begin
        if (pb.play_button) begin
          state_d = ST_PAUSED;
        end else if (pb.next_button) begin
          state_d = ST_LOAD; ret_d = ST_PLAYING; song_d = song_inc(song_q);
        end else if (pb.prev_button) begin
          state_d = ST_LOAD; ret_d = ST_PLAYING; song_d = song_dec(song_q);
        end else if (pb.song_done) begin
          state_d = ST_LOAD;
          case (pb.repeat_mode)
            RPT_ONE: ret_d = ST_PLAYING;
            RPT_ALL: begin ret_d = ST_PLAYING; song_d = song_inc(song_q); end
            default: begin ret_d = ST_PAUSED;  song_d = song_inc(song_q); end
          endcase
        end
      end
      ST_LOAD: state_d = ret_q;
      default: state_d = ST_PAUSED;
    endcase

    play_d         = (state_d == ST_PLAYING);
    reset_player_d = (state_d == ST_LOAD);
    new_frame_d    = pb.new_frame;
    gen_d          = pb.new_frame & ~new_frame_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_PAUSED;
      ret_q          <= ST_PAUSED;
      song_q         <= '0;
      play_q         <= 1'b0;
      reset_player_q <= 1'b0;
      new_frame_q    <= 1'b0;
      gen_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      ret_q          <= ret_d;
      song_q         <= song_d;
      play_q         <= play_d;
      reset_player_q <= reset_player_d;
      new_frame_q    <= new_frame_d;
      gen_q          <= gen_d;
    end
  end

  tempo_beat_counter #(
    .BEAT_COUNT(BEAT_COUNT),
    .CNT_W     (CNT_W)
  ) u_beat (
    .clk  (clk),
    .reset(reset),
    .clear(state_q == ST_LOAD),
    .en   (gen_q & play_q),
    .tempo(pb.tempo),
    .beat (pb.beat)
  );

  assign pb.play                 = play_q;
  assign pb.reset_player         = reset_player_q;
  assign pb.song                 = song_q;
  assign pb.generate_next_sample = gen_q;
  assign pb.state                = state_q;

endmodule

// File: tb/tb_playback_controller.sv
// Directed bench for playback_controller with NUM_SONGS=3, BEAT_COUNT=100.
module tb_playback_controller;
  import playback_pkg::*;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  int   beat_cnt;
  int   gen_cnt;

  playback_if #(.SONG_W(2)) pb();

  playback_controller #(
    .NUM_SONGS (3),
    .SONG_W    (2),
    .BEAT_COUNT(100),
    .CNT_W     (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .pb   (pb.slave)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pb.beat) beat_cnt++;
    if (pb.generate_next_sample) gen_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_play();
    pb.play_button = 1'b1; tick(); pb.play_button = 1'b0;
  endtask

  task automatic press_next();
    pb.next_button = 1'b1; tick(); pb.next_button = 1'b0;
  endtask

  task automatic press_prev();
    pb.prev_button = 1'b1; tick(); pb.prev_button = 1'b0;
  endtask

  task automatic pulse_done();
    pb.song_done = 1'b1; tick(); pb.song_done = 1'b0;
  endtask

  task automatic send_frames(input int n, input int half);
    for (int i = 0; i < n; i++) begin
      pb.new_frame = 1'b1;
      repeat (half) tick();
      pb.new_frame = 1'b0;
      repeat (half) tick();
    end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    beat_cnt       = 0;
    gen_cnt        = 0;
    reset          = 1'b1;
    pb.play_button = 1'b0;
    pb.next_button = 1'b0;
    pb.prev_button = 1'b0;
    pb.repeat_mode = RPT_OFF;
    pb.tempo       = TEMPO_NORMAL;
    pb.new_frame   = 1'b0;
    pb.song_done   = 1'b0;
    repeat (3) tick();

    check("rst_play", pb.play, 0);
    check("rst_song", pb.song, 0);
    check("rst_reset_player", pb.reset_player, 0);
    check("rst_beat", pb.beat, 0);
    check("rst_gen", pb.generate_next_sample, 0);
    check("rst_state", pb.state, ST_PAUSED);
    reset = 1'b0;
    tick();

    // play, then 100 frames of 60 cycles -> 100 samples, one beat
    press_play();
    check("play_on", pb.play, 1);
    beat_cnt = 0; gen_cnt = 0;
    send_frames(100, 30);
    repeat (4) tick();
    check("frames_gen_cnt", gen_cnt, 100);
    check("frames_beat_cnt", beat_cnt, 1);

    // pause, then prev at song 0 wraps to 2
    press_play();
    check("pause", pb.play, 0);
    press_prev();
    check("prev_wrap_song", pb.song, 2);
    check("prev_rp_high", pb.reset_player, 1);
    check("prev_load_play", pb.play, 0);
    tick();
    check("prev_rp_low", pb.reset_player, 0);
    check("prev_after_play", pb.play, 0);
    check("prev_after_state", pb.state, ST_PAUSED);

    // repeat-all from last song wraps and keeps playing
    press_play();
    pb.repeat_mode = RPT_ALL;
    pulse_done();
    check("rall_song", pb.song, 0);
    check("rall_rp_high", pb.reset_player, 1);
    tick();
    check("rall_rp_low", pb.reset_player, 0);
    check("rall_play", pb.play, 1);

    // back to song 2 while playing, then repeat off stops
    press_prev();
    check("prev_play_song", pb.song, 2);
    tick();
    check("prev_play_keep", pb.play, 1);
    pb.repeat_mode = RPT_OFF;
    pulse_done();
    check("roff_song", pb.song, 0);
    check("roff_rp_high", pb.reset_player, 1);
    tick();
    check("roff_play", pb.play, 0);
    check("roff_state", pb.state, ST_PAUSED);

    // repeat-one keeps song and playing
    press_play();
    pb.repeat_mode = RPT_ONE;
    pulse_done();
    check("rone_song", pb.song, 0);
    check("rone_rp_high", pb.reset_player, 1);
    tick();
    check("rone_play", pb.play, 1);

    // play beats next in the same cycle
    pb.next_button = 1'b1;
    press_play();
    pb.next_button = 1'b0;
    check("prio_play", pb.play, 0);
    check("prio_song", pb.song, 0);
    check("prio_rp", pb.reset_player, 0);
    check("prio_state", pb.state, ST_PAUSED);

    // next wraps 0 -> 1 -> 2 -> 0
    press_next(); tick();
    check("next_song1", pb.song, 1);
    press_next(); tick();
    check("next_song2", pb.song, 2);
    press_next(); tick();
    check("next_wrap", pb.song, 0);

    // buttons ignored during LOAD
    press_next();
    check("ign_in_load", pb.state, ST_LOAD);
    press_play();
    check("ign_state", pb.state, ST_PAUSED);
    check("ign_play", pb.play, 0);
    check("ign_song", pb.song, 1);

    // tempo change mid-count, then half tempo
    press_play();
    beat_cnt = 0;
    send_frames(70, 2);
    check("tempo_70_nobeat", beat_cnt, 0);
    pb.tempo = TEMPO_DOUBLE;
    send_frames(1, 2);
    check("tempo_double_fire", beat_cnt, 1);
    pb.tempo = TEMPO_HALF;
    beat_cnt = 0;
    send_frames(199, 2);
    check("tempo_half_199", beat_cnt, 0);
    send_frames(1, 2);
    check("tempo_half_200", beat_cnt, 1);

    // reset during LOAD
    press_next();
    check("rl_in_load", pb.state, ST_LOAD);
    check("rl_song_before", pb.song, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rl_song", pb.song, 0);
    check("rl_play", pb.play, 0);
    check("rl_rp", pb.reset_player, 0);
    check("rl_beat", pb.beat, 0);
    check("rl_gen", pb.generate_next_sample, 0);
    check("rl_state", pb.state, ST_PAUSED);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
